// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu), one quotient bit per cycle.
// Optional early-out for divide-by-zero or |x| < |y| is enabled by defining DIV_EARLY_OUT_EN.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             complete,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             divzero;
    logic             done_q;

    logic             x_neg, y_neg, accept, early_out;
    logic [WIDTH-1:0] x_mag, y_mag, q_fix, r_fix;
    logic [WIDTH:0]   shifted, trial;

    assign x_neg  = div_signed & x[WIDTH-1];
    assign y_neg  = div_signed & y[WIDTH-1];
    assign x_mag  = x_neg ? -x : x;
    assign y_mag  = y_neg ? -y : y;
    assign accept = div_valid & div_ready & ~cancel;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (y == '0) || (x_mag < y_mag);
`else
    assign early_out = 1'b0;
`endif

    // Partial remainder always stays below the divisor, so its top bit is zero before
    // the shift; after the trial subtract that bit becomes the borrow/sign flag.
    assign shifted = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    // With y == 0 the remainder ends as |x|, so the remainder sign fix restores x exactly.
    assign q_fix = sign_q ? -quo : quo;
    assign r_fix = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    // Outputs are registered except for the cancel gate on the completion pulse,
    // which lets a flush in DONE suppress the pulse in that same cycle.
    assign complete = done_q & ~cancel;

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state     <= IDLE;
            div_ready <= 1'b1;
            done_q    <= 1'b0;
            s         <= '0;
            r         <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            divzero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor   <= y_mag;
                        sign_q    <= x_neg ^ y_neg;
                        sign_r    <= x_neg;
                        divzero   <= (y == '0);
                        count     <= '0;
                        div_ready <= 1'b0;
                        if (early_out) begin
                            rem   <= {1'b0, x_mag};
                            quo   <= '0;
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            quo   <= x_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state     <= IDLE;
                        div_ready <= 1'b1;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial;
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (cancel) begin
                        state     <= IDLE;
                        div_ready <= 1'b1;
                    end else begin
                        s      <= divzero ? '1 : q_fix;
                        r      <= r_fix;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done_q    <= 1'b0;
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
